munoc_elog_queue_slave: RTL and testbench
=========================================

Name: munoc_elog_queue_slave

Overview:
Parametrised NoC self-register slave. It answers single-beat register accesses to the NoC's own address window, which has two regions: INFO and ELOG. Every access to an undefined address is logged into a depth-configurable error-log queue, together with error records pushed by other NoC blocks. Software drains the queue by reads and pops, and can take an interrupt while entries are pending.

Parameters:
BW_ADDR, 32, request address width
BW_DATA, 32, register data width (≥32)
BW_MASTER_ID, 4, master node ID width
LOG_DEPTH, 4, queue entries; power of 2, ≥2
BW_OVF, 8, saturating overflow counter width
NUM_MASTER, 4, value reported in INFO
NUM_SLAVE, 4, value reported in INFO
BASEADDR, 32'hF000_0000, window base; only the top 8 bits are compared

Ports:
clk  in  1  clock
rstnn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1 = write
req_addr  in  BW_ADDR  byte address
req_wdata  in  BW_DATA  write data
req_master_id  in  BW_MASTER_ID  requesting master
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_rdata  out  BW_DATA  read data (0 on writes and errors)
resp_error  out  1  access was unmapped
ext_log_valid  in  1  external error record offered
ext_log_ready  out  1  external record accepted
ext_log_write  in  1  record rw bit
ext_log_addr  in  BW_ADDR  record address
ext_log_master  in  BW_MASTER_ID  record master
irq  out  1  log-pending interrupt

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, irq=0, ext_log_ready=1. Queue empty, overflow counter=0, irq_enable=0.
- FSM has three states: IDLE, ACCESS, RESP.
  - IDLE→ACCESS on req_valid. req_ready = (state==IDLE). Address, rw, wdata and master ID are latched.
  - ACCESS→RESP unconditionally. Decode, writes and read-data capture happen in ACCESS.
  - RESP→IDLE on resp_ready. resp_valid=(state==RESP). resp_rdata and resp_error are held stable in RESP.
  - Latency: request accepted at cycle T gives resp_valid at T+2. The next request can be accepted in the cycle after the resp handshake.
- Decode: mapped iff addr[BW_ADDR-1-:8]==BASEADDR[BW_ADDR-1-:8] and addr[15:12] is 0 (INFO) or 1 (ELOG). An undefined word offset inside a region reads 0 and ignores writes, but is mapped. addr[1:0] are ignored.
- INFO region (read-only): 0x00 NUM_MASTER, 0x04 NUM_SLAVE, 0x08 requesting master ID, 0x0C LOG_DEPTH.
- ELOG region:
  - 0x00 COUNT (RO)
  - 0x04 OVERFLOW (RO; a write of any value clears it)
  - 0x08 HEAD_RW, 0x0C HEAD_ADDR, 0x10 HEAD_MASTER (RO; 0 when empty)
  - 0x14 HEAD_TIMESTAMP (optional feature)
  - 0x18 POP (a write pops one entry)
  - 0x1C IRQ_ENABLE (RW, bit 0)
- Unmapped access: in ACCESS, push {write, addr, master} and set resp_error=1, rdata=0.
- Push arbitration: the local push has priority. ext_log_ready = !(state==ACCESS & unmapped). An external push happens on ext_log_valid & ext_log_ready.
- Full queue: the new record is dropped and the oldest entries are kept. OVERFLOW increments and saturates at 2^BW_OVF−1. Local and external pushes are never both accepted in one cycle.
- POP on an empty queue is ignored; no error.
- POP together with an external push while full: the pop is applied first, so the push succeeds and OVERFLOW is unchanged.
- Pointers wrap modulo LOG_DEPTH. COUNT ranges over 0..LOG_DEPTH and is clog2(LOG_DEPTH)+1 bits wide.
- irq is registered: irq <= irq_enable & (COUNT!=0), one-cycle lag.
- Reset mid-transaction: all state returns to reset values immediately; a pending response and all queue contents are lost.

Optional Feature:
MUNOC_ELOG_TIMESTAMP_EN
- With the macro: a 32-bit free-running cycle counter (reset 0, wraps) is stored in every entry at push time. HEAD_TIMESTAMP at 0x14 returns the head entry's value.
- Without the macro: no counter and no storage for it; 0x14 reads 0.

Decomposition:
- munoc_elog_pkg holds the region codes, register offsets, FSM state encodings and the entry-width function.
- Sub-module munoc_elog_fifo (a synchronous FIFO with count, full/empty and pop-before-push on the same cycle) holds the queue. The top module contains the FSM, decode and counters.

Test Plan:
- Read 0xF000_0004 from master 3 → resp_valid at T+2, rdata=4, resp_error=0. Read 0xF000_0008 → 3.
- Read 0x1234_0000 from master 2 → resp_error=1, rdata=0. Then ELOG 0xF000_1000 reads 1, 0x100C reads 0x1234_0000, 0x1010 reads 2, 0x1008 reads 0.
- LOG_DEPTH=4: six unmapped writes → COUNT=4, OVERFLOW=2, head is the first address. Write 0x1004 → OVERFLOW=0.
- Write IRQ_ENABLE=1 with an empty queue → irq=0. One unmapped access → irq=1 one cycle after the push. Four POP writes → irq=0, and further POPs are ignored with COUNT=0.
- ext_log_valid held high during a local unmapped ACCESS → ext_log_ready=0 in that cycle, external record accepted the next cycle, queue order local then external.
- Drive rstnn low while in RESP with resp_ready=0 → resp_valid=0 immediately, COUNT=0, irq=0. With MUNOC_ELOG_TIMESTAMP_EN, entries pushed at cycles 10 and 25 after reset read back timestamps differing by 15.

Source files
------------

// File: rtl/munoc_elog_pkg.sv
// munoc_elog_pkg: region codes, register offsets, FSM states and queue entry width for the NoC self-register slave.
// Entries carry a 32-bit timestamp only when MUNOC_ELOG_TIMESTAMP_EN is defined.
package munoc_elog_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
    localparam logic [3:0] REGION_INFO = 4'h0;
    localparam logic [3:0] REGION_ELOG = 4'h1;
    localparam logic [11:0] INFO_NUM_MASTER = 12'h000;
    localparam logic [11:0] INFO_NUM_SLAVE = 12'h004;
    localparam logic [11:0] INFO_MASTER_ID = 12'h008;
    localparam logic [11:0] INFO_LOG_DEPTH = 12'h00C;
    localparam logic [11:0] ELOG_COUNT = 12'h000;
    localparam logic [11:0] ELOG_OVERFLOW = 12'h004;
    localparam logic [11:0] ELOG_HEAD_RW = 12'h008;
    localparam logic [11:0] ELOG_HEAD_ADDR = 12'h00C;
    localparam logic [11:0] ELOG_HEAD_MASTER = 12'h010;
    localparam logic [11:0] ELOG_HEAD_TS = 12'h014;
    localparam logic [11:0] ELOG_POP = 12'h018;
    localparam logic [11:0] ELOG_IRQ_EN = 12'h01C;
`ifdef MUNOC_ELOG_TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif
    function automatic int entry_width(input int bw_addr, input int bw_master);
        return TS_W + 1 + bw_addr + bw_master;
    endfunction
endpackage

// File: rtl/munoc_elog_fifo.sv
// munoc_elog_fifo: synchronous FIFO with count and drop flag; a pop in the same cycle frees room for a push.
module munoc_elog_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic full, pop_en, push_en;
    assign empty_o = count_q == '0;
    assign full = count_q == (AW+1)'(DEPTH);
    assign pop_en = pop_i && !empty_o;
    assign push_en = push_i && (!full || pop_en);
    assign drop_o = push_i && !push_en;
    assign dout_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
        end
    end
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/munoc_elog_queue_slave.sv
// munoc_elog_queue_slave: NoC self-register slave (INFO/ELOG regions) logging unmapped accesses and external errors.
// Define MUNOC_ELOG_TIMESTAMP_EN to stamp each log entry with a free-running cycle counter.
module munoc_elog_queue_slave import munoc_elog_pkg::*; #(
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 32,
    parameter int BW_MASTER_ID = 4,
    parameter int LOG_DEPTH = 4,
    parameter int BW_OVF = 8,
    parameter int NUM_MASTER = 4,
    parameter int NUM_SLAVE = 4,
    parameter logic [BW_ADDR-1:0] BASEADDR = 32'hF000_0000
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [BW_ADDR-1:0]      req_addr,
    input  logic [BW_DATA-1:0]      req_wdata,
    input  logic [BW_MASTER_ID-1:0] req_master_id,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [BW_DATA-1:0]      resp_rdata,
    output logic                    resp_error,
    input  logic                    ext_log_valid,
    output logic                    ext_log_ready,
    input  logic                    ext_log_write,
    input  logic [BW_ADDR-1:0]      ext_log_addr,
    input  logic [BW_MASTER_ID-1:0] ext_log_master,
    output logic                    irq
);
    localparam int EW = entry_width(BW_ADDR, BW_MASTER_ID);
    localparam int CW = $clog2(LOG_DEPTH) + 1;
    state_e state_q;
    logic write_q, wbit_q, error_q, irq_en_q, irq_q;
    logic [BW_ADDR-1:0] addr_q;
    logic [BW_MASTER_ID-1:0] master_q;
    logic [BW_DATA-1:0] rdata_q, rd_val;
    logic [BW_OVF-1:0] ovf_q, ovf_d;
    logic [3:0] region;
    logic [11:0] offset;
    logic mapped, in_access, local_push, ext_push, elog_wr, pop, ovf_clr, empty, drop;
    logic [EW-1:0] fifo_din, fifo_dout, head;
    logic [CW-1:0] count;
    logic unused_ok;
    assign unused_ok = ^req_wdata[BW_DATA-1:1];
    assign region = addr_q[15:12];
    assign offset = {addr_q[11:2], 2'b00};
    assign mapped = addr_q[BW_ADDR-1-:8] == BASEADDR[BW_ADDR-1-:8] &&
                    (region == REGION_INFO || region == REGION_ELOG);
    assign in_access = state_q == ST_ACCESS;
    assign local_push = in_access && !mapped;
    assign ext_log_ready = !local_push;
    assign ext_push = ext_log_valid && ext_log_ready;
    assign elog_wr = in_access && mapped && write_q && region == REGION_ELOG;
    assign pop = elog_wr && offset == ELOG_POP;
    assign ovf_clr = elog_wr && offset == ELOG_OVERFLOW;
`ifdef MUNOC_ELOG_TIMESTAMP_EN
    logic [31:0] ts_q;
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) ts_q <= '0;
        else ts_q <= ts_q + 1'b1;
    end
    assign fifo_din = local_push ? {ts_q, write_q, addr_q, master_q}
                                 : {ts_q, ext_log_write, ext_log_addr, ext_log_master};
`else
    assign fifo_din = local_push ? {write_q, addr_q, master_q}
                                 : {ext_log_write, ext_log_addr, ext_log_master};
`endif
    munoc_elog_fifo #(.W(EW), .DEPTH(LOG_DEPTH)) u_fifo (
        .clk(clk), .rstnn(rstnn), .push_i(local_push || ext_push), .din_i(fifo_din),
        .pop_i(pop), .dout_o(fifo_dout), .count_o(count), .empty_o(empty), .drop_o(drop)
    );
    assign head = empty ? '0 : fifo_dout;
    always_comb begin
        rd_val = '0;
        if (region == REGION_INFO)
            case (offset)
                INFO_NUM_MASTER: rd_val = BW_DATA'(NUM_MASTER);
                INFO_NUM_SLAVE: rd_val = BW_DATA'(NUM_SLAVE);
                INFO_MASTER_ID: rd_val = BW_DATA'(master_q);
                INFO_LOG_DEPTH: rd_val = BW_DATA'(LOG_DEPTH);
                default: ;
            endcase
        else
            case (offset)
                ELOG_COUNT: rd_val = BW_DATA'(count);
                ELOG_OVERFLOW: rd_val = BW_DATA'(ovf_q);
                ELOG_HEAD_RW: rd_val = BW_DATA'(head[BW_MASTER_ID+BW_ADDR]);
                ELOG_HEAD_ADDR: rd_val = BW_DATA'(head[BW_MASTER_ID+:BW_ADDR]);
                ELOG_HEAD_MASTER: rd_val = BW_DATA'(head[BW_MASTER_ID-1:0]);
`ifdef MUNOC_ELOG_TIMESTAMP_EN
                ELOG_HEAD_TS: rd_val = BW_DATA'(head[EW-1-:32]);
`endif
                ELOG_IRQ_EN: rd_val = BW_DATA'(irq_en_q);
                default: ;
            endcase
    end
    // A clear and a dropped external record in the same cycle leave OVERFLOW at 1.
    always_comb begin
        ovf_d = ovf_clr ? '0 : ovf_q;
        ovf_d = (drop && ovf_d != '1) ? ovf_d + 1'b1 : ovf_d;
    end
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            wbit_q <= 1'b0;
            addr_q <= '0;
            master_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q <= 1'b0;
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= irq_en_q && count != '0;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    state_q <= ST_ACCESS;
                    write_q <= req_write;
                    wbit_q <= req_wdata[0];
                    addr_q <= req_addr;
                    master_q <= req_master_id;
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    rdata_q <= (mapped && !write_q) ? rd_val : '0;
                    error_q <= !mapped;
                    if (elog_wr && offset == ELOG_IRQ_EN) irq_en_q <= wbit_q;
                end
                ST_RESP: if (resp_ready) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign req_ready = state_q == ST_IDLE;
    assign resp_valid = state_q == ST_RESP;
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_munoc_elog_queue_slave.sv
// tb_munoc_elog_queue_slave: directed and random register traffic checked against a queue-based model of the error log.
module tb_munoc_elog_queue_slave;
    logic clk = 1'b0, rstnn = 1'b0;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_master_id = '0;
    logic resp_valid, resp_ready = 1'b0, resp_error, irq;
    logic [31:0] resp_rdata;
    logic ext_log_valid = 1'b0, ext_log_ready, ext_log_write = 1'b0;
    logic [31:0] ext_log_addr = '0;
    logic [3:0] ext_log_master = '0;
    always #5 clk = ~clk;

    munoc_elog_queue_slave dut (
        .clk(clk), .rstnn(rstnn), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_master_id(req_master_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .ext_log_valid(ext_log_valid), .ext_log_ready(ext_log_ready), .ext_log_write(ext_log_write),
        .ext_log_addr(ext_log_addr), .ext_log_master(ext_log_master), .irq(irq)
    );

    typedef struct packed {logic w; logic [31:0] a; logic [3:0] m;} rec_t;
    rec_t q[$];
    int ovf = 0;
    bit irq_en = 0;
    int checks = 0, errors = 0;
    logic [31:0] rd, rd2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [31:0] a);
        return a[31:24] == 8'hF0 && a[15:12] <= 4'd1;
    endfunction

    function automatic void model_push(input rec_t r);
        if (q.size() < 4) q.push_back(r);
        else if (ovf < 255) ovf++;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] m);
        logic [11:0] off = {a[11:2], 2'b00};
        rec_t h = q.size() != 0 ? q[0] : '0;
        if (a[15:12] == 4'd0)
            case (off)
                12'h000, 12'h004, 12'h00C: return 4;
                12'h008: return 32'(m);
                default: return 0;
            endcase
        case (off)
            12'h000: return q.size();
            12'h004: return ovf;
            12'h008: return 32'(h.w);
            12'h00C: return h.a;
            12'h010: return 32'(h.m);
            12'h01C: return 32'(irq_en);
            default: return 0;
        endcase
    endfunction

    function automatic void model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] m, output logic [31:0] erd, output bit eerr);
        logic [11:0] off = {a[11:2], 2'b00};
        eerr = !is_mapped(a);
        erd = 0;
        if (eerr) model_push('{w: w, a: a, m: m});
        else if (!w) erd = model_read(a, m);
        else if (a[15:12] == 4'd1) begin
            if (off == 12'h004) ovf = 0;
            if (off == 12'h018 && q.size() != 0) void'(q.pop_front());
            if (off == 12'h01C) irq_en = d[0];
        end
    endfunction

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input bit x, input rec_t xr, output logic [31:0] rdo);
        logic [31:0] erd;
        bit eerr, mp, ipre, ipost, tsr;
        int n;
        mp = is_mapped(a);
        tsr = 0;
`ifdef MUNOC_ELOG_TIMESTAMP_EN
        tsr = mp && a[15:12] == 4'd1 && a[11:2] == 10'h005;
`endif
        ipre = irq_en && q.size() != 0;
        model_access(w, a, d, m, erd, eerr);
        if (x) model_push(xr);
        ipost = irq_en && q.size() != 0;
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_master_id = m;
        chk("req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0;
        if (x) begin
            ext_log_valid = 1; ext_log_write = xr.w; ext_log_addr = xr.a; ext_log_master = xr.m;
            chk("ext_ready_access", ext_log_ready, mp);
        end
        n = 1;
        while (!resp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (x && mp) ext_log_valid = 0;
        end
        chk("latency", n, 2);
        if (x && !mp) chk("ext_ready_resp", ext_log_ready, 1);
        rdo = resp_rdata;
        if (!tsr) chk($sformatf("rdata@%h", a), resp_rdata, erd);
        chk($sformatf("error@%h", a), resp_error, eerr);
        chk("irq_pre", irq, ipre);
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        ext_log_valid = 0;
        chk("resp_done", resp_valid, 0);
        chk("irq_post", irq, ipost);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_error", resp_error, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ext_ready", ext_log_ready, 1);
        rstnn = 1;
        @(posedge clk); #1;

        acc(0, 32'hF000_0004, 0, 4'd3, 0, '0, rd); chk("info_num_slave", rd, 4);
        acc(0, 32'hF000_0008, 0, 4'd3, 0, '0, rd); chk("info_master", rd, 3);
        acc(0, 32'h1234_0000, 0, 4'd2, 0, '0, rd); chk("unmapped_rdata", rd, 0);
        acc(0, 32'hF000_1000, 0, 4'd0, 0, '0, rd); chk("count_1", rd, 1);
        acc(0, 32'hF000_100C, 0, 4'd0, 0, '0, rd); chk("head_addr", rd, 32'h1234_0000);
        acc(0, 32'hF000_1010, 0, 4'd0, 0, '0, rd); chk("head_master", rd, 2);
        acc(0, 32'hF000_1008, 0, 4'd0, 0, '0, rd); chk("head_rw", rd, 0);
        acc(1, 32'hF000_1018, 0, 4'd0, 0, '0, rd);

        for (int i = 0; i < 6; i++) acc(1, 32'h2000_0000 + 32'(i * 4), 0, 4'(i), 0, '0, rd);
        acc(0, 32'hF000_1000, 0, 4'd0, 0, '0, rd); chk("full_count", rd, 4);
        acc(0, 32'hF000_1004, 0, 4'd0, 0, '0, rd); chk("full_ovf", rd, 2);
        acc(0, 32'hF000_100C, 0, 4'd0, 0, '0, rd); chk("oldest_kept", rd, 32'h2000_0000);
        acc(1, 32'hF000_1004, 32'hDEAD, 4'd0, 0, '0, rd);
        acc(0, 32'hF000_1004, 0, 4'd0, 0, '0, rd); chk("ovf_cleared", rd, 0);
        acc(1, 32'hF000_1018, 0, 4'd0, 1, '{w: 1'b1, a: 32'h7000_0000, m: 4'd9}, rd);
        acc(0, 32'hF000_1004, 0, 4'd0, 0, '0, rd); chk("pop_push_ovf", rd, 0);
        acc(0, 32'hF000_1000, 0, 4'd0, 0, '0, rd); chk("pop_push_count", rd, 4);
        acc(0, 32'hF000_100C, 0, 4'd0, 0, '0, rd); chk("pop_push_head", rd, 32'h2000_0004);
        for (int i = 0; i < 4; i++) acc(1, 32'hF000_1018, 0, 4'd0, 0, '0, rd);

        acc(1, 32'hF000_101C, 1, 4'd0, 0, '0, rd); chk("irq_empty", irq, 0);
        acc(0, 32'h5555_0000, 0, 4'd1, 0, '0, rd); chk("irq_set", irq, 1);
        for (int i = 0; i < 4; i++) acc(1, 32'hF000_1018, 0, 4'd0, 0, '0, rd);
        chk("irq_drained", irq, 0);
        acc(0, 32'hF000_1000, 0, 4'd0, 0, '0, rd); chk("count_empty", rd, 0);

        acc(0, 32'h3000_0010, 0, 4'd5, 1, '{w: 1'b1, a: 32'h4000_0020, m: 4'd6}, rd);
        acc(0, 32'hF000_100C, 0, 4'd0, 0, '0, rd); chk("order_local", rd, 32'h3000_0010);
        acc(1, 32'hF000_1018, 0, 4'd0, 0, '0, rd);
        acc(0, 32'hF000_100C, 0, 4'd0, 0, '0, rd); chk("order_ext", rd, 32'h4000_0020);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, d;
            logic w;
            rec_t xr;
            int k, idx;
            k = $urandom_range(0, 5);
            w = 1'($urandom);
            d = $urandom;
            xr.w = 1'($urandom); xr.a = $urandom; xr.m = 4'($urandom);
            idx = $urandom_range(0, 8);
`ifdef MUNOC_ELOG_TIMESTAMP_EN
            if (idx == 5) idx = 6;
`endif
            case (k)
                0: a = {8'hF0, 8'($urandom), 4'h0, 10'($urandom_range(0, 4)), 2'($urandom)};
                1, 2: a = {8'hF0, 8'($urandom), 4'h1, 10'(idx), 2'($urandom)};
                3: a = $urandom;
                4: a = {8'hF0, 8'($urandom), 4'($urandom_range(2, 15)), 12'($urandom)};
                default: begin a = 32'hF000_1018; w = 1; end
            endcase
            acc(w, a, d, 4'($urandom), $urandom_range(0, 3) == 0, xr, rd);
        end

        acc(1, 32'hF000_101C, 1, 4'd0, 0, '0, rd);
        acc(0, 32'h6000_0000, 0, 4'd2, 0, '0, rd);
        req_valid = 1; req_write = 0; req_addr = 32'hF000_0000; req_master_id = 0;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        chk("in_resp", resp_valid, 1);
        rstnn = 0;
        #1;
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_irq", irq, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        q.delete(); ovf = 0; irq_en = 0;
        @(posedge clk); #1;
        rstnn = 1;
        acc(0, 32'hF000_1000, 0, 4'd0, 0, '0, rd); chk("rst_mid_count", rd, 0);

`ifdef MUNOC_ELOG_TIMESTAMP_EN
        ext_log_valid = 1; ext_log_write = 0; ext_log_addr = 32'h0A00_0000; ext_log_master = 1;
        chk("ts_ext_ready", ext_log_ready, 1);
        @(posedge clk); #1;
        ext_log_valid = 0;
        repeat (14) @(posedge clk);
        #1;
        ext_log_valid = 1; ext_log_addr = 32'h0B00_0000;
        @(posedge clk); #1;
        ext_log_valid = 0;
        model_push('{w: 1'b0, a: 32'h0A00_0000, m: 4'd1});
        model_push('{w: 1'b0, a: 32'h0B00_0000, m: 4'd1});
        acc(0, 32'hF000_1014, 0, 4'd0, 0, '0, rd);
        acc(1, 32'hF000_1018, 0, 4'd0, 0, '0, rd2);
        acc(0, 32'hF000_1014, 0, 4'd0, 0, '0, rd2);
        chk("ts_diff", rd2 - rd, 15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
